// File: rtl/pair_scan_pkg.sv
// Shared definitions for the serial equal-pair scan controller:
// FSM state encoding and the hit-count width derivation.
package pair_scan_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        REPORT = ST_REPORT
    } state_t;

    // A word of width bits has at most width-1 adjacent pairs.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/word_shifter.sv
// Load/shift-left word register presenting its MSB, with a bit index
// that flags the final bit of the word.
module word_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb,
    output logic             last
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [IW-1:0]    idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= din;
            idx  <= '0;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            idx  <= idx + IW'(1);
        end
    end

    assign msb  = sreg[WIDTH-1];
    assign last = (idx == LAST_IDX);

endmodule

// File: rtl/pair_scan_ctrl.sv
// Word-to-bit-serial sequencer: accepts a word, scans it MSB-first through
// an equal-pair detector, and reports the per-word hit count.
module pair_scan_ctrl
    import pair_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             hit,
    output logic             busy,
    output logic             out_valid,
    output logic [CNT_W-1:0] hit_count,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic             load;
    logic             shift;
    logic             msb;
    logic             last;
    logic             hist_bit;
    logic             hist_valid;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    assign load  = (state == IDLE) && in_valid;
    assign shift = (state == SHIFT);

    word_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (in_data),
        .msb   (msb),
        .last  (last)
    );

    // The detector compares the live bit with the previous one of the same word.
    assign ser_bit    = shift && msb;
    assign hit        = shift && hist_valid && (msb == hist_bit);
    assign count_next = (hit && (count != CNT_MAX)) ? count + CNT_W'(1) : count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            hit_count  <= '0;
            count      <= '0;
            hist_bit   <= 1'b0;
            hist_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state      <= SHIFT;
                        in_ready   <= 1'b0;
                        ser_valid  <= 1'b1;
                        busy       <= 1'b1;
                        count      <= '0;
                        hist_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    hist_bit   <= msb;
                    hist_valid <= 1'b1;
                    count      <= count_next;
                    // The final bit's hit is folded straight into the reported count.
                    if (last) begin
                        state      <= REPORT;
                        ser_valid  <= 1'b0;
                        out_valid  <= 1'b1;
                        hit_count  <= count_next;
                        hist_valid <= 1'b0;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_scan_ctrl.sv
// Self-checking bench for pair_scan_ctrl: directed words plus random traffic,
// compared every cycle against a word-level behavioural model.
module tb_pair_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          ser_bit;
    logic          ser_valid;
    logic          hit;
    logic          busy;
    logic          out_valid;
    logic [CW-1:0] hit_count;

    pair_scan_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .hit       (hit),
        .busy      (busy),
        .out_valid (out_valid),
        .hit_count (hit_count),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // Model: phase 0 = waiting for a word, 1..W = scanning bit k, W+1 = reporting.
    int           m_phase = 0;
    logic [W-1:0] m_word = '0;
    int           m_last = 0;
    int           edge_cnt = 0;
    int           d_acc = -1;
    int           d_prev_acc = -1;
    int           d_take = -1;

    function automatic int pair_count(input logic [W-1:0] w);
        int n = 0;
        for (int i = 0; i < W - 1; i++)
            if (w[i] == w[i+1]) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        edge_cnt++;
        if (rst && in_valid && in_ready === 1'b1) begin
            d_prev_acc = d_acc;
            d_acc      = edge_cnt;
        end
        if (rst && out_valid === 1'b1 && out_ready)
            d_take = edge_cnt;
        if (!rst) begin
            m_phase = 0;
            m_last  = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_word  = in_data;
                m_phase = 1;
            end
        end else if (m_phase <= W) begin
            m_phase++;
            if (m_phase == W + 1)
                m_last = pair_count(m_word);
        end else if (out_ready) begin
            m_phase = 0;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        logic eb;
        logic eh;
        if (!checking) return;
        eb = 1'b0;
        eh = 1'b0;
        if (m_phase >= 1 && m_phase <= W) begin
            eb = m_word[W - m_phase];
            if (m_phase >= 2)
                eh = (m_word[W - m_phase] == m_word[W - m_phase + 1]);
        end
        cmp("in_ready",  in_ready,  (m_phase == 0));
        cmp("busy",      busy,      (m_phase != 0));
        cmp("ser_valid", ser_valid, (m_phase >= 1 && m_phase <= W));
        cmp("ser_bit",   ser_bit,   eb);
        cmp("hit",       hit,       eh);
        cmp("out_valid", out_valid, (m_phase == W + 1));
        cmp("hit_count", hit_count, m_last);
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput();
    endtask

    // Steps until the result appears, then pins its count and the hits seen on the way.
    task automatic waitReport(input string name, input int exp);
        bit seen = 1'b0;
        int hits = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (hit === 1'b1) hits++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s: out_valid timeout, got none, expected within 40 cycles", name);
        end else begin
            cmp(name, hit_count, exp);
            cmp({name, "_hits"}, hits, exp);
        end
    endtask

    initial begin
        applyStimulus(1'b0, '0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        checking = 1'b1;
        step();
        cmp("rst_in_ready", in_ready, 1);
        cmp("rst_hit_count", hit_count, 0);
        rst = 1'b1;

        applyStimulus(1'b1, 8'hAA, 1'b1);
        waitReport("aa_count", 0);
        applyStimulus(1'b0, 8'hAA, 1'b1);
        step();

        applyStimulus(1'b1, 8'hFF, 1'b1);
        waitReport("ff_count", 7);
        applyStimulus(1'b0, 8'hFF, 1'b1);
        step();

        applyStimulus(1'b1, 8'hCC, 1'b1);
        waitReport("cc_count", 4);
        applyStimulus(1'b0, 8'hCC, 1'b1);
        step();

        applyStimulus(1'b1, 8'h01, 1'b1);
        waitReport("b2b_first", 6);
        step();
        applyStimulus(1'b1, 8'h80, 1'b1);
        waitReport("b2b_second", 6);
        applyStimulus(1'b0, 8'h80, 1'b1);
        cmp("b2b_gap", d_acc - d_prev_acc, W + 2);
        step();

        applyStimulus(1'b1, 8'hCC, 1'b0);
        waitReport("bp_count", 4);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        repeat (5) begin
            step();
            cmp("bp_count_stable", hit_count, 4);
            cmp("bp_in_ready", in_ready, 0);
            cmp("bp_busy", busy, 1);
        end
        applyStimulus(1'b1, 8'h5A, 1'b1);
        waitReport("bp_next", 1);
        cmp("bp_accept_delay", d_acc - d_take, 1);
        applyStimulus(1'b0, 8'h5A, 1'b1);
        step();

        applyStimulus(1'b1, 8'hFF, 1'b1);
        repeat (4) step();
        rst = 1'b0;
        applyStimulus(1'b0, 8'hFF, 1'b1);
        step();
        cmp("midrst_out_valid", out_valid, 0);
        cmp("midrst_busy", busy, 0);
        cmp("midrst_in_ready", in_ready, 1);
        cmp("midrst_ser_valid", ser_valid, 0);
        cmp("midrst_hit_count", hit_count, 0);
        rst = 1'b1;
        repeat (12) begin
            step();
            cmp("midrst_no_report", out_valid, 0);
        end
        applyStimulus(1'b1, 8'hAA, 1'b1);
        waitReport("post_rst_aa", 0);
        applyStimulus(1'b0, 8'hAA, 1'b1);
        step();

        for (int i = 0; i < 1500; i++) begin
            if (!(in_valid && m_phase != 0)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pair_scan_ctrl.md
# pair_scan_ctrl

Sequencing controller for the serial equal-pair detector. It accepts parallel words through a valid/ready handshake and shifts each word MSB-first through an embedded pair detector, one bit per cycle. It counts detector hits per word and returns the count through a second valid/ready handshake. It sits between a word-oriented producer and consumer and the bit-serial detection datapath.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2 and up.
- `CNT_W`, default `$clog2(WIDTH)`: hit-count width. Derived parameter; do not override. It holds the maximum of WIDTH-1 hits.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  WIDTH  word to scan.
- `in_ready`  out  1  controller accepts a word this cycle.
- `ser_bit`  out  1  bit currently presented to the detector.
- `ser_valid`  out  1  `ser_bit` is a live scan bit.
- `hit`  out  1  the bit presented this cycle completes an equal pair.
- `busy`  out  1  a word is in flight (SHIFT or REPORT).
- `out_valid`  out  1  `hit_count` is valid.
- `hit_count`  out  CNT_W  hits in the last scanned word.
- `out_ready`  in  1  consumer takes the result.

## Operation
- There are three states: IDLE, SHIFT and REPORT.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`: load `in_data` into the shifter, clear the bit index, clear the hit counter, clear the detector history, and go to SHIFT.
- **SHIFT**
  - `ser_valid`=1 and `ser_bit`=shifter MSB.
  - The shifter shifts left by one bit each cycle.
  - **Detector rule:** `hit`=1 when history is valid and `ser_bit`==previous bit. Runs overlap: bits 000 give 2 hits.
    - The first bit of each word has no history and never hits.
    - History does not carry across words.
  - The counter increments on every `hit`. After the WIDTH-th bit, which is counted, go to REPORT.
- **REPORT**
  - `out_valid`=1 and `hit_count` is held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready`=0 throughout REPORT, so a new word cannot be accepted in the same cycle the result is taken.
- The hit counter never wraps; WIDTH-1 is its maximum.
- Outside SHIFT: `ser_valid`=0, `hit`=0, and `ser_bit`=0.
- Outside REPORT: `out_valid`=0. `hit_count` holds its last value.
- `busy`=1 in SHIFT and REPORT.

## Timing
- **Reset** (`rst`=0 at a clock edge):
  - state=IDLE.
  - `in_ready`=1.
  - `ser_bit`, `ser_valid`, `hit`, `busy`, `out_valid`=0.
  - `hit_count`=0.
  - Reset takes effect in any state. A word mid-scan or a pending result is discarded with no `out_valid`.
- **Latency:**
  - Accept edge is cycle 0.
  - Bits are presented in cycles 1..WIDTH, MSB first.
  - `out_valid` rises in cycle WIDTH+1.
- **Throughput:** at least one IDLE cycle separates words, so the minimum is WIDTH+2 cycles per word when `out_ready` is held high.
- **Outputs:** `hit` and `ser_bit` are combinational from registered state, valid in the same cycle. All other outputs are registered or are decoded from the state register.
- **Backpressure:** `out_valid` and `hit_count` stay stable until `out_ready`. Producer `in_valid` may stay high indefinitely without effect.
- **Handshake:** the producer must hold `in_data` stable while `in_valid` is high and `in_ready` is low.

## Structure
- Package `pair_scan_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, REPORT=2'd2);
  - the CNT_W derivation function.
- Sub-module `word_shifter` is a WIDTH-bit load/shift-left register with MSB output and an internal bit index. It asserts `last` when the index equals WIDTH-1.
- The top level holds the FSM, the detector history register (one bit plus a valid flag), and the hit counter.

## Test plan
- **0xAA (10101010):** `ser_bit` sequence 1,0,1,0,1,0,1,0 in cycles 1–8 and `hit` never asserted. `hit_count`=0 with `out_valid` in cycle 9.
- **0xFF:** `hit`=0 in cycle 1 and `hit`=1 in cycles 2–8. `hit_count`=7, which is the saturation boundary.
- **0xCC (11001100):** hits in cycles 2, 4, 6 and 8. `hit_count`=4.
- **Back-to-back 0x01 then 0x80, `out_ready`=1:** each word reports 6. The first bit of the second word produces no hit, confirming no history carry. The second word is accepted exactly WIDTH+2 cycles after the first.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after 0xCC with `in_valid`=1 and the next word presented.
  - During the stall: `hit_count`=4 stable, `in_ready`=0, `busy`=1.
  - The next word is accepted in the cycle after `out_ready` is taken.
- **Reset mid-scan:** drive `rst`=0 during cycle 4 of 0xFF.
  - The next cycle shows all reset values and no `out_valid`.
  - A following 0xAA reports 0.
